eprobe_cmd_sequencer: RTL and testbench

//  Upstream feeder for the E-probe LED control stage. Buffers 16-bit command words
//  ([15:14] method | [13:11] VLED | [10] EN | [9:0] LEDADDR) from the host pipe-in
//  in a FIFO, then presents them one at a time on cmd. It waits for the control

---
 rtl/eprobe_cmd_sequencer_if.sv | 32 +++
 rtl/eprobe_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_eprobe_cmd_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eprobe_cmd_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : eprobe_cmd_sequencer_if                                         |
// | Brief    : Host write port, control-stage command port and status flags    |
// |            of the E-probe command sequencer.                               |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface eprobe_cmd_sequencer_if #(
    parameter int DEPTH_LOG2 = 5
);
    logic                  wr_en;
    logic [15:0]           wr_data;
    logic [1:0]            ctrl_state;
    logic [15:0]           cmd;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  busy;
    logic                  overflow;
    logic                  timeout;

    modport master (
        output wr_en, wr_data, ctrl_state,
        input  cmd, full, empty, count, busy, overflow, timeout
    );

    modport slave (
        input  wr_en, wr_data, ctrl_state,
        output cmd, full, empty, count, busy, overflow, timeout
    );
endinterface
`default_nettype wire

// File: rtl/eprobe_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : eprobe_cmd_sequencer                                            |
// | Brief    : FIFO-buffered command feeder for the E-probe LED control stage; |
// |            optional WAIT_DONE watchdog under EPROBE_SEQ_TIMEOUT_EN.        |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module eprobe_cmd_sequencer #(
    parameter int          DEPTH_LOG2 = 5,
    parameter int          START_WIN  = 4,
    parameter int          GAP_CYC    = 2,
    parameter logic [23:0] TIMEOUT    = 24'd4000
) (
    input  logic                  clk,
    input  logic                  rst,
    eprobe_cmd_sequencer_if.slave bus
);
    localparam int                  c_depth      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_count = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [7:0]          c_win_last   = 8'(START_WIN - 1);
    localparam logic [7:0]          c_gap_last   = 8'(GAP_CYC - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ISSUE      = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_WAIT_DONE  = 3'd3;
    localparam logic [2:0] S_GAP        = 3'd4;

    logic [15:0]           r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [15:0]           r_cmd;
    logic [15:0]           w_cmd_nxt;
    logic [7:0]            r_win;
    logic [7:0]            r_gap;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;

    assign w_full  = (r_count == c_full_count);
    assign w_empty = (r_count == '0);
    // A pop frees the head slot in the same cycle, so a write to a full FIFO can land.
    assign w_push  = bus.wr_en && (!w_full || w_pop);
    assign w_drop  = bus.wr_en && w_full && !w_pop;

`ifdef EPROBE_SEQ_TIMEOUT_EN
    logic [23:0] r_to_cnt;
    logic        r_timeout;
    logic        w_timeout_hit;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_pop       = 1'b0;
`ifdef EPROBE_SEQ_TIMEOUT_EN
        w_timeout_hit = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_cmd_nxt   = r_mem[r_rd_ptr];
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT_START;
            S_WAIT_START: begin
                if ((r_cmd[15:14] == 2'b00) || (r_cmd[15:14] == 2'b11) ||
                    ((bus.ctrl_state == 2'b00) && (r_win == c_win_last))) begin
                    w_state_nxt = S_GAP;
                    w_cmd_nxt   = {2'b00, r_cmd[13:0]};
                end else if (bus.ctrl_state != 2'b00) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.ctrl_state == 2'b00) begin
                    w_state_nxt = S_GAP;
                    w_cmd_nxt   = {2'b00, r_cmd[13:0]};
                end
`ifdef EPROBE_SEQ_TIMEOUT_EN
                else if (r_to_cnt == (TIMEOUT - 24'd1)) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = S_GAP;
                    w_cmd_nxt     = {2'b00, r_cmd[13:0]};
                end
`endif
            end
            S_GAP: begin
                if (r_gap == c_gap_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cmd      <= 16'h0000;
            r_win      <= 8'd0;
            r_gap      <= 8'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
            r_win   <= (r_state == S_WAIT_START) ? r_win + 8'd1 : 8'd0;
            r_gap   <= (r_state == S_GAP) ? r_gap + 8'd1 : 8'd0;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.wr_data;
    end

`ifdef EPROBE_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt  <= 24'd0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == S_WAIT_DONE) ? r_to_cnt + 24'd1 : 24'd0;
            if (w_timeout_hit) r_timeout <= 1'b1;
        end
    end
    assign bus.timeout = r_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign bus.timeout      = 1'b0;
`endif

    assign bus.cmd      = r_cmd;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = r_count;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.overflow = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_eprobe_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_eprobe_cmd_sequencer                                         |
// | Brief    : Self-checking bench for eprobe_cmd_sequencer with a behavioural |
// |            control-stage model and a command-order scoreboard.            |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_eprobe_cmd_sequencer;
    localparam int DL2      = 2;
    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_STUCK  = 2;

    typedef struct {
        logic        wr;
        logic [15:0] data;
        logic [15:0] cmd;
        logic        busy;
        logic        empty;
        logic [2:0]  count;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eprobe_cmd_sequencer_if #(.DEPTH_LOG2(DL2)) bus ();

    eprobe_cmd_sequencer #(
        .DEPTH_LOG2(DL2),
        .START_WIN (4),
        .GAP_CYC   (2),
        .TIMEOUT   (24'd4000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ctrl_mode = M_NORMAL;
    int busy_len  = 2;
    int ctrl_rem  = 0;
    int starts    = 0;
    logic [15:0] issue_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Control stage: starts on a changed word with an active method, busy for busy_len cycles.
    initial begin
        logic [15:0] prev_cmd;
        prev_cmd = 16'h0000;
        bus.ctrl_state = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (bus.ctrl_state == 2'b00) begin
                if ((bus.cmd !== prev_cmd) && ctrl_mode != M_NEVER &&
                    (bus.cmd[15:14] == 2'b01 || bus.cmd[15:14] == 2'b10)) begin
                    starts++;
                    bus.ctrl_state = 2'b01;
                    ctrl_rem = busy_len;
                end
            end else if (ctrl_mode != M_STUCK) begin
                ctrl_rem--;
                if (ctrl_rem <= 0) bus.ctrl_state = 2'b00;
            end
            prev_cmd = bus.cmd;
        end
    end

    // Every IDLE->busy transition is one issued command.
    initial begin
        logic prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1 && prev_busy === 1'b0) issue_log.push_back(bus.cmd);
            prev_busy = bus.busy;
        end
    end

    task automatic wr(input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic release_ctrl();
        ctrl_mode = M_NORMAL;
        ctrl_rem  = 1;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (!(bus.busy === 1'b0 && bus.empty === 1'b1) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) begin
            n_checks++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wr_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Busy cycles seen for one isolated word, and the separator left on cmd.
    task automatic busy_span(input logic [15:0] w, output int n);
        int guard;
        n = 0;
        guard = 0;
        wr(w);
        while (guard < 50) begin
            @(negedge clk);
            guard++;
            if (bus.busy === 1'b1) n++;
            else if (n > 0) break;
        end
    endtask

    initial begin
        vec_t vt [20];
        logic [15:0] exp_q[$];
        logic [15:0] w;
        int exp_starts;
        int n;
        int nw;

        vt[0]  = '{1'b1, 16'h4C05, 16'h0000, 1'b0, 1'b0, 3'd1};
        vt[1]  = '{1'b0, 16'h0000, 16'h4C05, 1'b1, 1'b1, 3'd0};
        vt[2]  = '{1'b0, 16'h0000, 16'h4C05, 1'b1, 1'b1, 3'd0};
        vt[3]  = '{1'b0, 16'h0000, 16'h4C05, 1'b1, 1'b1, 3'd0};
        vt[4]  = '{1'b0, 16'h0000, 16'h0C05, 1'b1, 1'b1, 3'd0};
        vt[5]  = '{1'b0, 16'h0000, 16'h0C05, 1'b1, 1'b1, 3'd0};
        vt[6]  = '{1'b0, 16'h0000, 16'h0C05, 1'b0, 1'b1, 3'd0};
        vt[7]  = '{1'b1, 16'h4C05, 16'h0C05, 1'b0, 1'b0, 3'd1};
        vt[8]  = '{1'b1, 16'h4C05, 16'h4C05, 1'b1, 1'b0, 3'd1};
        vt[9]  = '{1'b0, 16'h0000, 16'h4C05, 1'b1, 1'b0, 3'd1};
        vt[10] = '{1'b0, 16'h0000, 16'h4C05, 1'b1, 1'b0, 3'd1};
        vt[11] = '{1'b0, 16'h0000, 16'h0C05, 1'b1, 1'b0, 3'd1};
        vt[12] = '{1'b0, 16'h0000, 16'h0C05, 1'b1, 1'b0, 3'd1};
        vt[13] = '{1'b0, 16'h0000, 16'h0C05, 1'b0, 1'b0, 3'd1};
        vt[14] = '{1'b0, 16'h0000, 16'h4C05, 1'b1, 1'b1, 3'd0};
        vt[15] = '{1'b0, 16'h0000, 16'h4C05, 1'b1, 1'b1, 3'd0};
        vt[16] = '{1'b0, 16'h0000, 16'h4C05, 1'b1, 1'b1, 3'd0};
        vt[17] = '{1'b0, 16'h0000, 16'h0C05, 1'b1, 1'b1, 3'd0};
        vt[18] = '{1'b0, 16'h0000, 16'h0C05, 1'b1, 1'b1, 3'd0};
        vt[19] = '{1'b0, 16'h0000, 16'h0C05, 1'b0, 1'b1, 3'd0};

        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_cmd", 32'(bus.cmd), 32'h0);
        check("rst_flags", {26'b0, bus.full, bus.empty, bus.busy, bus.overflow, bus.timeout, 1'b0},
              {26'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check("rst_count", 32'(bus.count), 32'h0);
        rst = 1'b0;

        // Single pixel followed by two identical back-to-back commands.
        busy_len = 2;
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            bus.wr_en = vt[i].wr;
            bus.wr_data = vt[i].data;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {11'b0, bus.cmd, bus.busy, bus.empty, bus.count},
                  {11'b0, vt[i].cmd, vt[i].busy, vt[i].empty, vt[i].count});
        end
        bus.wr_en = 1'b0;
        check("vec_starts", 32'(starts), 32'd3);

        // Fill while stalled, write-with-pop on full, then a dropped write.
        do_reset();
        issue_log.delete();
        ctrl_mode = M_STUCK;
        wr(16'h4111);
        repeat (4) @(negedge clk);
        wr(16'h8222); wr(16'h4333); wr(16'h0444); wr(16'hC555);
        check("fill_count", 32'(bus.count), 32'd4);
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_ovf", 32'(bus.overflow), 32'd0);
        check("stall_timeout", 32'(bus.timeout), 32'd0);
        release_ctrl();
        n = 0;
        while (bus.busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        check("release_idle", 32'(bus.busy), 32'd0);
        wr(16'h4666);
        check("popwr_count", 32'(bus.count), 32'd4);
        check("popwr_ovf", 32'(bus.overflow), 32'd0);
        check("popwr_cmd", 32'(bus.cmd), 32'h8222);
        wr(16'h4777);
        check("drop_ovf", 32'(bus.overflow), 32'd1);
        check("drop_count", 32'(bus.count), 32'd4);
        wait_idle(300);
        exp_q = '{16'h4111, 16'h8222, 16'h4333, 16'h0444, 16'hC555, 16'h4666};
        check("fill_nissue", 32'(issue_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < issue_log.size(); i++)
            check($sformatf("fill_issue%0d", i), 32'(issue_log[i]), 32'(exp_q[i]));

        // No-op methods skip the start window; a start that never comes costs START_WIN.
        n = starts;
        busy_span(16'h0123, nw);
        check("noop00_busy", 32'(nw), 32'd4);
        check("noop00_sep", 32'(bus.cmd), 32'h0123);
        busy_span(16'hC123, nw);
        check("noop11_busy", 32'(nw), 32'd4);
        check("noop11_sep", 32'(bus.cmd), 32'h0123);
        ctrl_mode = M_NEVER;
        busy_span(16'h4000, nw);
        check("nostart_busy", 32'(nw), 32'd7);
        check("nostart_sep", 32'(bus.cmd), 32'h0000);
        check("noop_starts", 32'(starts), 32'(n));
        ctrl_mode = M_NORMAL;

        // Reset while waiting on the control stage with three words queued.
        ctrl_mode = M_STUCK;
        wr(16'h4888);
        repeat (4) @(negedge clk);
        wr(16'h4001); wr(16'h4002); wr(16'h4003);
        check("q3_count", 32'(bus.count), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cmd", 32'(bus.cmd), 32'h0);
        check("midrst_state", {27'b0, bus.count, bus.empty, bus.busy},
              {27'b0, 3'd0, 1'b1, 1'b0});
        check("midrst_ovf", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        release_ctrl();
        repeat (3) @(negedge clk);
        check("midrst_quiet", {30'b0, bus.busy, bus.empty}, {30'b0, 1'b0, 1'b1});

`ifdef EPROBE_SEQ_TIMEOUT_EN
        ctrl_mode = M_STUCK;
        wr(16'h4999);
        @(negedge clk);
        n = 0;
        while (bus.timeout !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        check("to_latency", 32'(n), 32'd4002);
        check("to_flag", 32'(bus.timeout), 32'd1);
        check("to_sep", 32'(bus.cmd), 32'h0999);
        n = 0;
        while (bus.busy !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        check("to_proceed", 32'(bus.busy), 32'd0);
        release_ctrl();
        repeat (2) @(negedge clk);
`else
        check("to_absent", 32'(bus.timeout), 32'd0);
`endif

        // Random bursts from an idle sequencer; every word must be issued in order.
        do_reset();
        issue_log.delete();
        exp_q.delete();
        starts = 0;
        exp_starts = 0;
        for (int b = 0; b < 25; b++) begin
            wait_idle(100);
            busy_len = $urandom_range(2, 5);
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) begin
                w = 16'($urandom);
                exp_q.push_back(w);
                if (w[15:14] == 2'b01 || w[15:14] == 2'b10) exp_starts++;
                wr(w);
            end
        end
        wait_idle(300);
        check("rnd_nissue", 32'(issue_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < issue_log.size(); i++)
            check($sformatf("rnd_issue%0d", i), 32'(issue_log[i]), 32'(exp_q[i]));
        check("rnd_starts", 32'(starts), 32'(exp_starts));
        check("rnd_ovf", 32'(bus.overflow), 32'd0);
        check("rnd_sep", 32'(bus.cmd), 32'({2'b00, exp_q[exp_q.size()-1][13:0]}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
